// File: rtl/cv32e40p_illegal_rec_pkg.sv
// Shared types and constants for the illegal-instruction event recorder.
package cv32e40p_illegal_rec_pkg;

    localparam int REC_TS_W  = 32;
    localparam int OVF_CNT_W = 16;

    typedef struct packed {
        logic [31:0]         pc;
        logic [3:0]          hart;
        logic [REC_TS_W-1:0] ts;
    } rec_entry_t;

endpackage

// File: rtl/cv32e40p_illegal_rec_fifo.sv
// Small synchronous FIFO with show-ahead head output; full/empty derived from the occupancy count.
module cv32e40p_illegal_rec_fifo
    import cv32e40p_illegal_rec_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = rec_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   wdata,
    output entry_t                   rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // When full with a simultaneous pop, wr_ptr == rd_ptr: the slot is overwritten
    // only after the departing head has been read this cycle.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/cv32e40p_illegal_insn_recorder.sv
// Records illegal-instruction decode events (PC, hart, timestamp) into a FIFO drained over valid/ready.
// Optional repeat suppression for a stalled ID stage: define CV32E40P_ILLEGAL_REC_DEDUP_EN.
module cv32e40p_illegal_insn_recorder
    import cv32e40p_illegal_rec_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = REC_TS_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   is_decoding_i,
    input  logic                   illegal_insn_dec_i,
    input  logic [31:0]            hart_id_i,
    input  logic [31:0]            pc_id_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [31:0]            rd_pc_o,
    output logic [3:0]             rd_hart_o,
    output logic [TS_WIDTH-1:0]    rd_timestamp_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic [OVF_CNT_W-1:0]   overflow_cnt_o
);

    typedef struct packed {
        logic [31:0]         pc;
        logic [3:0]          hart;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    logic [TS_WIDTH-1:0]  ts_q;
    logic                 overflow_q;
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    logic   evt, cand, push, pop, drop;
    logic   full, empty;
    entry_t wdata, head;
    logic   unused_hart;

    assign unused_hart = ^hart_id_i[31:4];
    assign evt = is_decoding_i && illegal_insn_dec_i;

`ifdef CV32E40P_ILLEGAL_REC_DEDUP_EN
    logic        prev_evt_q;
    logic [31:0] prev_pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_evt_q <= 1'b0;
            prev_pc_q  <= '0;
        end else if (clear_i) begin
            prev_evt_q <= 1'b0;
            prev_pc_q  <= '0;
        end else begin
            prev_evt_q <= evt;
            prev_pc_q  <= pc_id_i;
        end
    end

    assign cand = evt && !(prev_evt_q && (prev_pc_q == pc_id_i));
`else
    assign cand = evt;
`endif

    // clear_i wins over everything; a full FIFO still accepts when the head leaves this cycle.
    assign pop  = !empty && rd_ready_i && !clear_i;
    assign push = cand && (!full || pop) && !clear_i;
    assign drop = cand && full && !pop && !clear_i;

    assign wdata.pc   = pc_id_i;
    assign wdata.hart = hart_id_i[3:0];
    assign wdata.ts   = ts_q;

    cv32e40p_illegal_rec_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (clear_i),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .count (count_o),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign rd_valid_o     = !empty;
    assign rd_pc_o        = empty ? '0 : head.pc;
    assign rd_hart_o      = empty ? '0 : head.hart;
    assign rd_timestamp_o = empty ? '0 : head.ts;
    assign overflow_o     = overflow_q;
    assign overflow_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_cv32e40p_illegal_insn_recorder.sv
// Directed + random bench for the illegal-instruction recorder against a queue-based reference model.
module tb_cv32e40p_illegal_insn_recorder;

    localparam int DEPTH    = 4;
    localparam int TS_WIDTH = 32;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic is_dec = 1'b0;
    logic ill = 1'b0;
    logic ready = 1'b0;
    logic [31:0] hart = '0;
    logic [31:0] pc = '0;

    logic                rd_valid;
    logic [31:0]         rd_pc;
    logic [3:0]          rd_hart;
    logic [TS_WIDTH-1:0] rd_ts;
    logic [CW-1:0]       count;
    logic                ovf;
    logic [15:0]         ovf_cnt;

    cv32e40p_illegal_insn_recorder #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear),
        .is_decoding_i      (is_dec),
        .illegal_insn_dec_i (ill),
        .hart_id_i          (hart),
        .pc_id_i            (pc),
        .rd_valid_o         (rd_valid),
        .rd_ready_i         (ready),
        .rd_pc_o            (rd_pc),
        .rd_hart_o          (rd_hart),
        .rd_timestamp_o     (rd_ts),
        .count_o            (count),
        .overflow_o         (ovf),
        .overflow_cnt_o     (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  hart;
        logic [31:0] ts;
    } ent_t;

    ent_t        q[$];
    int unsigned m_ts;
    bit          m_ovf;
    int          m_cnt;
    bit          m_prev_evt;
    logic [31:0] m_prev_pc;
    bit          quiet = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
        m_prev_evt = 1'b0;
        m_prev_pc = '0;
    endtask

    // Applies one clock edge's worth of the recorder's rules to the model.
    task automatic model_edge();
        bit   evt, cand, popped;
        ent_t e;
        evt = is_dec && ill;
`ifdef CV32E40P_ILLEGAL_REC_DEDUP_EN
        cand = evt && !(m_prev_evt && (m_prev_pc == pc));
`else
        cand = evt;
`endif
        if (clear) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
            m_prev_evt = 1'b0;
            m_prev_pc = '0;
        end else begin
            popped = (q.size() > 0) && ready;
            if (popped) void'(q.pop_front());
            if (cand) begin
                if (q.size() < DEPTH) begin
                    e.pc = pc; e.hart = hart[3:0]; e.ts = m_ts;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            m_prev_evt = evt;
            m_prev_pc = pc;
        end
        m_ts++;
    endtask

    task automatic check_all(input string tag);
        bit ne;
        ne = q.size() > 0;
        chk({tag, ".valid"}, 64'(rd_valid), 64'(ne));
        chk({tag, ".pc"},    64'(rd_pc),    ne ? 64'(q[0].pc)   : 64'd0);
        chk({tag, ".hart"},  64'(rd_hart),  ne ? 64'(q[0].hart) : 64'd0);
        chk({tag, ".ts"},    64'(rd_ts),    ne ? 64'(q[0].ts)   : 64'd0);
        chk({tag, ".count"}, 64'(count),    64'(q.size()));
        chk({tag, ".ovf"},   64'(ovf),      64'(m_ovf));
        chk({tag, ".ovfcnt"}, 64'(ovf_cnt), 64'(m_cnt));
    endtask

    task automatic cyc(input bit evt, input logic [31:0] pcv, input logic [31:0] hv,
                       input bit rdy, input bit clr, input string tag);
        is_dec = evt;
        ill = evt;
        pc = pcv;
        hart = hv;
        ready = rdy;
        clear = clr;
        @(posedge clk);
        model_edge();
        #1;
        if (!quiet) check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "idle");
    endtask

    initial begin
        int unsigned base;
        model_reset();

        // Reset state
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single event at timestamp 10
        idle(10);
        cyc(1'b1, 32'h0000_1000, 32'h25, 1'b0, 1'b0, "single_evt");
        chk("single.valid", 64'(rd_valid), 64'd1);
        chk("single.pc",    64'(rd_pc),    64'h1000);
        chk("single.hart",  64'(rd_hart),  64'h5);
        chk("single.ts",    64'(rd_ts),    64'd10);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "single_pop");

        // Six distinct events into a 4-deep FIFO
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 32'h100 + 32'(i * 4), 32'(i), 1'b0, 1'b0, "fill6");
        chk("fill6.count",  64'(count),   64'd4);
        chk("fill6.ovf",    64'(ovf),     64'd1);
        chk("fill6.ovfcnt", 64'(ovf_cnt), 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk("drain6.pc", 64'(rd_pc), 64'(32'h100 + 32'(i * 4)));
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain6");
        end
        chk("drain6.empty", 64'(rd_valid), 64'd0);

        // Full, then event with simultaneous pop
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'h300 + 32'(i * 4), 32'h1, 1'b0, 1'b0, "full");
        cyc(1'b1, 32'h0000_0ABC, 32'h1, 1'b1, 1'b0, "full_pushpop");
        chk("pushpop.count",  64'(count),   64'd4);
        chk("pushpop.ovfcnt", 64'(ovf_cnt), 64'd2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain_pp");
        chk("pushpop.last_pc", 64'(rd_pc), 64'h0ABC);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain_pp");

        // clear with event while count=3, overflow_cnt=1
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "pre_clear");
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h400 + 32'(i * 4), 32'h2, 1'b0, 1'b0, "fill_clr");
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "pop_clr");
        chk("preclr.count",  64'(count),   64'd3);
        chk("preclr.ovfcnt", 64'(ovf_cnt), 64'd1);
        cyc(1'b1, 32'h500, 32'h2, 1'b1, 1'b1, "clear_evt");
        chk("clear.count",  64'(count),    64'd0);
        chk("clear.ovf",    64'(ovf),      64'd0);
        chk("clear.ovfcnt", 64'(ovf_cnt),  64'd0);
        chk("clear.valid",  64'(rd_valid), 64'd0);

        // Event held for three cycles at one PC
        base = m_ts;
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h2000, 32'h3, 1'b0, 1'b0, "hold");
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "hold_end");
`ifdef CV32E40P_ILLEGAL_REC_DEDUP_EN
        chk("hold.count", 64'(count), 64'd1);
        chk("hold.ts0",   64'(rd_ts), 64'(base));
`else
        chk("hold.count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("hold.ts", 64'(rd_ts), 64'(base + i));
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "hold_drain");
        end
`endif
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "post_hold_clr");

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 2)), $urandom,
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0), "rand");

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h600 + 32'(i * 4), 32'h7, 1'b0, 1'b0, "pre_rst");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midreset");
        chk("midreset.count", 64'(count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h700, 32'h9, 1'b0, 1'b0, "post_rst");
        chk("postrst.ts", 64'(rd_ts), 64'd0);

        // Saturation of the dropped-event counter
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "sat_clr");
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h800 + 32'(i * 4), 32'h0, 1'b0, 1'b0, "sat_fill");
        quiet = 1'b1;
        for (int i = 0; i < 32'h10000 + 3; i++) begin
            cyc(1'b1, 32'h900 + 32'(i[0] * 4), 32'h0, 1'b0, 1'b0, "sat");
            if (i == 32'hFFFD) begin
                chk("sat.pre", 64'(ovf_cnt), 64'hFFFE);
            end
        end
        quiet = 1'b0;
        check_all("sat_end");
        chk("sat.ovfcnt", 64'(ovf_cnt), 64'hFFFF);
        chk("sat.count",  64'(count),   64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
